// File: rtl/led_blink_multi.sv
// N-channel LED blinker with shared prescaler, phase counter,
// per-channel switch synchroniser/debouncer and 2-bit mode select.
module led_blink_multi #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sw,
    input  logic [2*N_CH-1:0] mode,
    input  logic              restart,
    output logic [N_CH-1:0]   led,
    output logic              tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

    logic [PW-1:0]   pcnt;
    logic [1:0]      phase;
    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] sw_stable;
    logic [DW-1:0]   dcnt [N_CH];
    logic [N_CH-1:0] fsel;

    // Shared prescaler; restart wins over terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end
    end

    // Blink phase advances once per tick; bit0 fast, bit1 slow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'd0;
        end else if (restart) begin
            phase <= 2'd0;
        end else if (tick) begin
            if (phase == 2'd3) begin
                phase <= 2'd0;
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Accept a switch level only after DEB_CYCLES differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] != sw_stable[i]) begin
                    if (dcnt[i] == DMAX) begin
                        sw_stable[i] <= s2[i];
                        dcnt[i]      <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Per-channel mode decode: off, steady, fast, slow
    always_comb begin
        fsel = '0;
        for (int i = 0; i < N_CH; i++) begin
            unique case (mode[2*i +: 2])
                2'b00:   fsel[i] = 1'b0;
                2'b01:   fsel[i] = 1'b1;
                2'b10:   fsel[i] = phase[0];
                default: fsel[i] = phase[1];
            endcase
        end
    end

    // Registered LED drive gated by the debounced switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= sw_stable & fsel;
        end
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Bench for led_blink_multi: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_led_blink_multi;

    localparam int NC  = 2;
    localparam int TD  = 4;
    localparam int DEB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] sw = '0;
    logic [2*NC-1:0] mode = '0;
    logic          restart = 1'b0;
    logic [NC-1:0] led;
    logic          tick;

    int n_chk = 0;
    int n_fail = 0;

    led_blink_multi #(
        .N_CH(NC),
        .TICK_DIV(TD),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .mode(mode),
        .restart(restart),
        .led(led),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: c = clock edges since reset release or last restart.
    // Ticks fall on every TD-th such edge; phase counts ticks
    // already seen before the current edge.
    int            c = 0;
    bit [NC-1:0]   h1, h2, mst;
    int            run [NC];
    bit [NC-1:0]   e_led;
    bit            e_tick;

    function automatic int phase_of(input int cc);
        if (cc == 0) return 0;
        return ((cc - 1) / TD) % 4;
    endfunction

    function automatic bit fmode(input bit [1:0] m, input int ph);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return ph[0];
            default: return ph[1];
        endcase
    endfunction

    always @(posedge clk) begin
        int pph;
        bit [NC-1:0] pst;
        bit [NC-1:0] din;
        if (!rst_n) begin
            c = 0;
            h1 = '0;
            h2 = '0;
            mst = '0;
            for (int i = 0; i < NC; i++) run[i] = 0;
            #1;
            chk("rst_led", led, 0);
            chk("rst_tick", tick, 0);
        end else begin
            pph = phase_of(c);
            pst = mst;
            c = restart ? 0 : c + 1;
            e_tick = (c > 0) && (c % TD == 0);
            for (int i = 0; i < NC; i++)
                e_led[i] = pst[i] & fmode(mode[2*i +: 2], pph);
            din = h2;
            h2 = h1;
            h1 = sw;
            for (int i = 0; i < NC; i++) begin
                if (din[i] != mst[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        mst[i] = din[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            #1;
            chk("model_tick", tick, e_tick);
            chk("model_led", led, e_led);
        end
    end

    int hold [NC];
    int highs;
    bit found;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Tick pulses on edges 4 and 8 after release, led stays low
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk("t1_tick", tick, (k == 4 || k == 8));
            chk("t1_led", led, 0);
        end

        // Steady ch0: led[0] rises exactly 6 cycles after sw edge
        @(negedge clk);
        sw = 2'b01;
        mode = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("t2_led", led, (k == 6) ? 2'b01 : 2'b00);
        end

        // Fast blink: 8 of any 16 cycles high
        @(negedge clk);
        mode = 4'b0010;
        highs = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            highs += int'(led[0]);
        end
        chk("t3_fast_highs", highs, 8);

        // Slow blink: 16 of any 32 cycles high
        @(negedge clk);
        mode = 4'b0011;
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            highs += int'(led[0]);
        end
        chk("t3_slow_highs", highs, 16);

        // Two-cycle glitch must be rejected
        @(negedge clk);
        sw = 2'b00;
        mode = 4'b0001;
        repeat (10) @(negedge clk);
        sw = 2'b01;
        repeat (2) @(negedge clk);
        sw = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            chk("t4_glitch_led", led, 0);
        end

        // Restart on the terminal-count cycle
        @(negedge clk);
        sw = 2'b11;
        mode = 4'b1010;
        repeat (10) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            found = tick;
        end
        chk("t5_tick_seen", found, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_no_tick", tick, 0);
        @(negedge clk);
        restart = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("t5_tick_after", tick, (k == 4));
            chk("t5_phase0_led", led, 0);
        end
        @(posedge clk);
        #1;
        chk("t5_led_on", led, 2'b11);

        // Async reset mid-blink clears led before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_led", led, 0);
        chk("t6_async_tick", tick, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("t6_tick_after", tick, (k == 4));
            chk("t6_led_after", led, 0);
        end

        // Randomized run against the model
        for (int i = 0; i < NC; i++) hold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            restart = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0)
                mode = 4'($urandom);
            for (int i = 0; i < NC; i++) begin
                if (hold[i] == 0) begin
                    sw[i] = 1'($urandom);
                    hold[i] = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
        end
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
